axis_ifmap_pack_fifo: RTL and testbench
=======================================

AXIS_IFMAP_PACK_FIFO -- requirements
Module: axis_ifmap_pack_fifo

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
 DATA_W, 32, AXIS beat width
 ELEM_W, 5, bits per ifmap element
 MAC_NUM, 256, elements per packed row (output width ELEM_W*MAC_NUM)
 DEPTH, 4, row slots; power of two, >=2
 CH_W, 12, width of cfg_channels
 EPB, derived = floor(DATA_W/ELEM_W) (6 at defaults), elements per beat; element k of a beat = tdata[k*ELEM_W +: ELEM_W]
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
 clk  in  1  clock
 rst_n  in  1  reset, asynchronous, active-low
 s_axis_tdata  in  DATA_W  packed elements
 s_axis_tvalid  in  1  beat valid
 s_axis_tready  out  1  beat accepted when tvalid&tready
 s_axis_tlast  in  1  last beat of row
 cfg_channels  in  CH_W  elements per row
 cfg_load  in  1  latch cfg_channels
 flush  in  1  synchronous clear of FIFO state
 m_data  out  ELEM_W*MAC_NUM  head row; element i at [i*ELEM_W +: ELEM_W]
 m_valid  out  1  head row present
 m_ready  in  1  consumer pops head when m_valid&m_ready
 fifo_cnt  out  clog2(DEPTH)+1  committed rows
 fifo_empty  out  1  fifo_cnt==0
 fifo_full  out  1  fifo_cnt==DEPTH
 err_tlast  out  1  one-cycle tlast/count mismatch pulse

Function
REQ-003 SHALL latch ch_eff = cfg_channels on cfg_load only when no row is partially assembled (elem_idx==0); cfg_load mid-row ignored.
REQ-004 SHALL clamp ch_eff: 0 or >MAC_NUM -> MAC_NUM.
REQ-005 SHALL assemble each row directly in slot wr_ptr; elem_idx starts at 0, accepted beat writes elements elem_idx..elem_idx+n-1 with n=min(EPB, ch_eff-elem_idx), then elem_idx += EPB.
REQ-006 SHALL zero all elements of a slot not written during its row (positions >= ch_eff, tail of short rows), at latest when the row commits.
REQ-007 SHALL commit a row on the accepted beat where elem_idx+EPB >= ch_eff or s_axis_tlast=1: wr_ptr+1 (mod DEPTH), elem_idx -> 0, row visible at m_data/m_valid next cycle.
REQ-008 SHALL pulse err_tlast one cycle after a committing beat whose tlast disagrees with count completion (early tlast -> short zero-padded row; missing tlast -> row commits anyway).
REQ-009 SHALL drive s_axis_tready = ~flush & (~fifo_full | (m_valid & m_ready)).
REQ-010 SHALL present head slot combinationally (first-word fall-through): m_data = slot[rd_ptr], m_valid = ~fifo_empty.
REQ-011 SHALL advance rd_ptr (mod DEPTH) and decrement fifo_cnt on pop; commit increments fifo_cnt; simultaneous commit and pop leave fifo_cnt unchanged.
REQ-012 SHALL never overflow/underflow: pop ignored when empty, beats not accepted when full without pop.
REQ-013 flush SHALL take priority over all events: next cycle wr_ptr=rd_ptr=elem_idx=fifo_cnt=0, err_tlast=0, ch_eff held; beat/pop in flush cycle discarded.

Reset
REQ-014 SHALL on rst_n low asynchronously clear wr_ptr, rd_ptr, elem_idx, fifo_cnt, err_tlast, all slots to 0, ch_eff to MAC_NUM; outputs: m_valid=0, fifo_empty=1, fifo_full=0, m_data=0, s_axis_tready=1 (after reset release).
REQ-015 SHALL discard a partially assembled row on reset mid-operation.

Verification
REQ-016 Defaults, ch=256, 43 beats tdata elements=beat index, tlast on beat 43 -> one row, elements 0..251 per beat, 252..255 from beat 43 elems 0..3, fifo_cnt=1, no err.
REQ-017 ch=10, 2 beats, tlast on 2nd -> row elements 0..9 from data, 10..255 zero; commit next cycle.
REQ-018 ch=256, tlast on beat 5 -> row elements 0..29 data, rest zero; err_tlast one-cycle pulse.
REQ-019 Write 4 rows, m_ready=0 -> fifo_full=1, tready=0; then m_ready=1 with beat completing a 5th row same cycle -> fifo_cnt stays 4, rows pop in order.
REQ-020 Assert rst_n low mid-row (elem_idx=18) and separately flush with 2 rows stored -> fifo_cnt=0, m_valid=0, next row packs from element 0.
REQ-021 cfg_load with ch=12 mid-row -> ignored until row commits; cfg_channels=0 -> 256-element rows.

Source files
------------

// File: rtl/axis_ifmap_pack_fifo.sv
// AXI-Stream ifmap packer: assembles ELEM_W-bit elements into MAC_NUM-wide
// rows directly in a small FWFT row FIFO.
module axis_ifmap_pack_fifo #(
  parameter int DATA_W  = 32,
  parameter int ELEM_W  = 5,
  parameter int MAC_NUM = 256,
  parameter int DEPTH   = 4,
  parameter int CH_W    = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [CH_W-1:0]           cfg_channels,
  input  logic                      cfg_load,
  input  logic                      flush,
  output logic [ELEM_W*MAC_NUM-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic                      fifo_empty,
  output logic                      fifo_full,
  output logic                      err_tlast
);

  localparam int EPB = DATA_W / ELEM_W;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int IW  = $clog2(MAC_NUM + EPB + 1);
  localparam int RW  = ELEM_W * MAC_NUM;

  localparam logic [IW-1:0] EPB_I = IW'(EPB);
  localparam logic [IW-1:0] MAC_I = IW'(MAC_NUM);

  logic [RW-1:0] slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] elem_idx;
  logic [IW-1:0] ch_eff;
  logic [IW-1:0] ch_new;
  logic [IW-1:0] rem;
  logic [IW-1:0] n_wr;
  logic          accept;
  logic          pop;
  logic          cnt_done;
  logic          commit;

  generate
    if (DATA_W > EPB * ELEM_W) begin : g_pad
      logic unused_tdata;
      assign unused_tdata = ^s_axis_tdata[DATA_W-1:EPB*ELEM_W];
    end
  endgenerate

  always_comb begin
    fifo_empty    = (fifo_cnt == '0);
    fifo_full     = (fifo_cnt == CW'(DEPTH));
    m_valid       = ~fifo_empty;
    m_data        = slots[rd_ptr];
    s_axis_tready = ~flush & (~fifo_full | (m_valid & m_ready));
    accept        = s_axis_tvalid & s_axis_tready;
    pop           = m_valid & m_ready & ~flush;
    rem           = ch_eff - elem_idx;
    n_wr          = (rem < EPB_I) ? rem : EPB_I;
    cnt_done      = (elem_idx + EPB_I) >= ch_eff;
    commit        = accept & (cnt_done | s_axis_tlast);
    ch_new        = IW'(cfg_channels);
    if (cfg_channels == '0 || 32'(cfg_channels) > MAC_NUM)
      ch_new = MAC_I;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      elem_idx  <= '0;
      fifo_cnt  <= '0;
      err_tlast <= 1'b0;
      ch_eff    <= MAC_I;
      for (int i = 0; i < DEPTH; i++)
        slots[i] <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      elem_idx  <= '0;
      fifo_cnt  <= '0;
      err_tlast <= 1'b0;
    end else begin
      err_tlast <= commit & (s_axis_tlast ^ cnt_done);
      if (cfg_load && elem_idx == '0)
        ch_eff <= ch_new;
      if (accept) begin
        // first beat clears the slot so unwritten tail reads as zero
        if (elem_idx == '0)
          slots[wr_ptr] <= '0;
        for (int k = 0; k < EPB; k++)
          if (IW'(k) < n_wr)
            slots[wr_ptr][(int'(elem_idx) + k)*ELEM_W +: ELEM_W]
              <= s_axis_tdata[k*ELEM_W +: ELEM_W];
        if (commit) begin
          elem_idx <= '0;
          wr_ptr   <= wr_ptr + PW'(1);
        end else begin
          elem_idx <= elem_idx + EPB_I;
        end
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        commit & ~pop: fifo_cnt <= fifo_cnt + CW'(1);
        pop & ~commit: fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ifmap_pack_fifo.sv
// Bench for axis_ifmap_pack_fifo: queue-based row model checked every
// cycle, plus directed literal expectations.
module tb_axis_ifmap_pack_fifo;

  localparam int DATA_W  = 32;
  localparam int ELEM_W  = 5;
  localparam int MAC_NUM = 256;
  localparam int DEPTH   = 4;
  localparam int CH_W    = 12;
  localparam int EPB     = DATA_W / ELEM_W;
  localparam int RW      = ELEM_W * MAC_NUM;

  typedef logic [RW-1:0] row_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [CH_W-1:0]   cfg_channels;
  logic              cfg_load;
  logic              flush;
  row_t              m_data;
  logic              m_valid;
  logic              m_ready;
  logic [2:0]        fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              err_tlast;

  axis_ifmap_pack_fifo #(
    .DATA_W(DATA_W), .ELEM_W(ELEM_W), .MAC_NUM(MAC_NUM),
    .DEPTH(DEPTH), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .cfg_channels(cfg_channels), .cfg_load(cfg_load), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_cnt(fifo_cnt), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   started = 0;

  // model state
  row_t q[$];
  row_t acc_row;
  int   beats;
  int   ch;
  bit   err_e;
  int   m_cnt;
  int   m_n;
  bit   m_acc;
  bit   m_pop;
  bit   m_done;
  bit   m_first;
  int   c_cnt;

  function automatic int clampf(input int c);
    return (c == 0 || c > MAC_NUM) ? MAC_NUM : c;
  endfunction

  function automatic logic [4:0] el(input row_t v, input int i);
    return v[i*ELEM_W +: ELEM_W];
  endfunction

  function automatic logic [DATA_W-1:0] rep(input int v);
    logic [DATA_W-1:0] r;
    logic [4:0] e;
    r = '0;
    e = 5'(v);
    for (int k = 0; k < EPB; k++) r[k*ELEM_W +: ELEM_W] = e;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] seq(input int s);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < EPB; k++) r[k*ELEM_W +: ELEM_W] = 5'(s + k);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_row(input string nm, input row_t got, input row_t exp);
    int first;
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      first = -1;
      for (int i = MAC_NUM - 1; i >= 0; i--)
        if (el(got, i) !== el(exp, i)) first = i;
      $display("FAIL %s: element %0d got %0d expected %0d at %0t",
               nm, first, el(got, first), el(exp, first), $time);
    end
  endtask

  // behavioural model: rows as whole vectors in a queue
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete(); acc_row = '0; beats = 0; ch = MAC_NUM; err_e = 0;
    end else if (flush) begin
      q.delete(); acc_row = '0; beats = 0; err_e = 0;
    end else begin
      m_cnt   = q.size();
      m_first = (beats == 0);
      m_acc   = s_axis_tvalid && (m_cnt < DEPTH || (m_cnt > 0 && m_ready));
      m_pop   = (m_cnt > 0) && m_ready;
      err_e   = 0;
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        m_n = ch - beats * EPB;
        if (m_n > EPB) m_n = EPB;
        for (int k = 0; k < m_n; k++)
          acc_row[(beats*EPB + k)*ELEM_W +: ELEM_W] =
            s_axis_tdata[k*ELEM_W +: ELEM_W];
        m_done = ((beats + 1) * EPB >= ch);
        if (m_done || s_axis_tlast) begin
          q.push_back(acc_row);
          acc_row = '0;
          beats = 0;
          err_e = (s_axis_tlast != m_done);
        end else begin
          beats++;
        end
      end
      if (cfg_load && m_first) ch = clampf(int'(cfg_channels));
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (rst_n && started) begin
      c_cnt = q.size();
      chk("fifo_cnt", 32'(fifo_cnt), c_cnt);
      chk("m_valid", 32'(m_valid), 32'(c_cnt > 0));
      chk("fifo_empty", 32'(fifo_empty), 32'(c_cnt == 0));
      chk("fifo_full", 32'(fifo_full), 32'(c_cnt == DEPTH));
      chk("err_tlast", 32'(err_tlast), 32'(err_e));
      chk("s_axis_tready", 32'(s_axis_tready),
          32'(!flush && (c_cnt < DEPTH || (c_cnt > 0 && m_ready))));
      if (c_cnt > 0) chk_row("m_data", m_data, q[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic last);
    bit ok;
    ok = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = s_axis_tready;
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("beat_accept", 32'(ok), 1);
  endtask

  task automatic cfg(input int v);
    cfg_channels = CH_W'(v);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic pop1();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; cfg_channels = '0; cfg_load = 1'b0;
    flush = 1'b0; m_ready = 1'b0;
    #22 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_fifo_empty", 32'(fifo_empty), 1);
    chk("rst_fifo_full", 32'(fifo_full), 0);
    chk("rst_tready", 32'(s_axis_tready), 1);
    chk_row("rst_m_data", m_data, '0);
    started = 1;
    step();

    // full 256-element row, 43 beats
    for (int b = 0; b < 43; b++) beat(rep(b), b == 42);
    chk("r16_cnt", 32'(fifo_cnt), 1);
    chk("r16_e0", 32'(el(m_data, 0)), 0);
    chk("r16_e6", 32'(el(m_data, 6)), 1);
    chk("r16_e251", 32'(el(m_data, 251)), 9);
    chk("r16_e252", 32'(el(m_data, 252)), 10);
    chk("r16_e255", 32'(el(m_data, 255)), 10);
    chk("r16_err", 32'(err_tlast), 0);
    pop1();

    // ch=10, tlast on 2nd beat
    cfg(10);
    beat(seq(1), 1'b0);
    beat(seq(7), 1'b1);
    chk("r17_cnt", 32'(fifo_cnt), 1);
    chk("r17_e0", 32'(el(m_data, 0)), 1);
    chk("r17_e9", 32'(el(m_data, 9)), 10);
    chk("r17_e10", 32'(el(m_data, 10)), 0);
    chk("r17_err", 32'(err_tlast), 0);
    pop1();
    // ch=10, missing tlast
    beat(seq(1), 1'b0);
    beat(seq(7), 1'b0);
    chk("miss_err", 32'(err_tlast), 1);
    step();
    chk("miss_err_clr", 32'(err_tlast), 0);
    pop1();

    // ch=256, early tlast on beat 5
    cfg(256);
    for (int b = 0; b < 5; b++) beat(rep(b + 1), b == 4);
    chk("r18_err", 32'(err_tlast), 1);
    chk("r18_e29", 32'(el(m_data, 29)), 5);
    chk("r18_e30", 32'(el(m_data, 30)), 0);
    step();
    chk("r18_err_clr", 32'(err_tlast), 0);
    pop1();

    // fill, then pop and commit in the same cycle
    cfg(6);
    for (int r = 0; r < 4; r++) beat(seq(r * 3), 1'b1);
    chk("r19_full", 32'(fifo_full), 1);
    chk("r19_tready", 32'(s_axis_tready), 0);
    m_ready = 1'b1;
    beat(seq(20), 1'b1);
    m_ready = 1'b0;
    chk("r19_cnt", 32'(fifo_cnt), 4);
    chk("r19_head_e0", 32'(el(m_data, 0)), 3);
    m_ready = 1'b1;
    repeat (5) step();
    m_ready = 1'b0;
    chk("r19_empty", 32'(fifo_empty), 1);

    // async reset mid-row
    cfg(256);
    for (int b = 0; b < 3; b++) beat(rep(b + 1), 1'b0);
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    step();
    chk("r20_rst_cnt", 32'(fifo_cnt), 0);
    chk("r20_rst_valid", 32'(m_valid), 0);
    beat(rep(7), 1'b1);
    chk("r20_rst_e0", 32'(el(m_data, 0)), 7);
    chk("r20_rst_e6", 32'(el(m_data, 6)), 0);
    pop1();

    // flush with 2 rows stored and a partial row
    cfg(12);
    beat(seq(1), 1'b0); beat(seq(7), 1'b1);
    beat(seq(2), 1'b0); beat(seq(8), 1'b1);
    beat(seq(3), 1'b0);
    chk("r20_pre_cnt", 32'(fifo_cnt), 2);
    flush = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = rep(9);
    m_ready = 1'b1;
    step();
    flush = 1'b0; s_axis_tvalid = 1'b0; m_ready = 1'b0;
    chk("r20_fl_cnt", 32'(fifo_cnt), 0);
    chk("r20_fl_valid", 32'(m_valid), 0);
    beat(seq(4), 1'b0);
    beat(seq(10), 1'b1);
    chk("r20_fl_e0", 32'(el(m_data, 0)), 4);
    chk("r20_fl_e6", 32'(el(m_data, 6)), 10);
    chk("r20_fl_e11", 32'(el(m_data, 11)), 15);
    chk("r20_fl_err", 32'(err_tlast), 0);
    pop1();

    // cfg 0 -> 256; mid-row cfg_load ignored
    cfg(0);
    beat(rep(1), 1'b0);
    cfg(12);
    for (int b = 1; b < 43; b++) beat(rep(b + 1), b == 42);
    chk("r21_cnt", 32'(fifo_cnt), 1);
    chk("r21_e12", 32'(el(m_data, 12)), 3);
    chk("r21_e255", 32'(el(m_data, 255)), 11);
    chk("r21_err", 32'(err_tlast), 0);
    pop1();
    beat(rep(5), 1'b1);
    chk("r21_still256", 32'(err_tlast), 1);
    pop1();
    cfg(12);
    beat(seq(1), 1'b0);
    beat(seq(7), 1'b1);
    chk("r21_ch12_err", 32'(err_tlast), 0);
    chk("r21_ch12_e11", 32'(el(m_data, 11)), 12);
    pop1();
    cfg(300);
    beat(rep(2), 1'b1);
    chk("clamp_err", 32'(err_tlast), 1);
    pop1();

    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
